// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared widths, arrow/nucleotide codes and fill FSM states for the NW fill sequencer
package nw_pkg;

  localparam int SCORE_W = 9;
  localparam int DIR_W   = 3;

  localparam logic [DIR_W-1:0] ARROW_LX   = 3'b100;
  localparam logic [DIR_W-1:0] ARROW_UP   = 3'b010;
  localparam logic [DIR_W-1:0] ARROW_DIAG = 3'b001;

  localparam logic [1:0] NT_A = 2'd0;
  localparam logic [1:0] NT_C = 2'd1;
  localparam logic [1:0] NT_G = 2'd2;
  localparam logic [1:0] NT_T = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    FETCH = 3'd2,
    CALC  = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } fill_state_t;

endpackage

// File: rtl/nw_row_buf.sv
// rtl/nw_row_buf.sv - one-row score buffer, combinational read port and synchronous write port
module nw_row_buf
  import nw_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [CW-1:0]             waddr,
  input  logic signed [SCORE_W-1:0] wdata,
  input  logic [CW-1:0]             raddr,
  output logic signed [SCORE_W-1:0] rdata
);

  // Contents are rebuilt by the INIT pass of every fill, so no reset is needed.
  logic signed [SCORE_W-1:0] mem_q [0:N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/nw_fill_ctrl.sv
// rtl/nw_fill_ctrl.sv - Needleman-Wunsch score-matrix fill sequencer; NW_FILL_ABORT_EN adds an abort input
module nw_fill_ctrl
  import nw_pkg::*;
#(
  parameter int N   = 8,
  parameter int GAP = -1,
  parameter int AW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
`ifdef NW_FILL_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [AW-1:0]             seq_a_addr,
  input  logic [1:0]                seq_a_data,
  output logic [AW-1:0]             seq_b_addr,
  input  logic [1:0]                seq_b_data,
  output logic                      mx_value,
  output logic signed [SCORE_W-1:0] mx_diag,
  output logic signed [SCORE_W-1:0] mx_up,
  output logic signed [SCORE_W-1:0] mx_lx,
  input  logic signed [SCORE_W-1:0] mx_max,
  input  logic [DIR_W-1:0]          mx_symbol,
  input  logic                      mx_calc,
  output logic                      dir_we,
  output logic [AW-1:0]             dir_row,
  output logic [AW-1:0]             dir_col,
  output logic [DIR_W-1:0]          dir_data,
  output logic signed [SCORE_W-1:0] final_score
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);
  localparam logic signed [SCORE_W-1:0] GAP_S = SCORE_W'(GAP);

  fill_state_t state_q;
  logic [CW-1:0] i_q, j_q;
  logic signed [SCORE_W-1:0] diag_q, left_q, row0_q, init_val_q;

  logic busy_q, done_q, mx_value_q, dir_we_q;
  logic [AW-1:0] seq_a_addr_q, seq_b_addr_q, dir_row_q, dir_col_q;
  logic signed [SCORE_W-1:0] mx_diag_q, mx_up_q, mx_lx_q, final_q;
  logic [DIR_W-1:0] dir_data_q;

  logic abort_hit;
  logic buf_we;
  logic signed [SCORE_W-1:0] buf_wdata, buf_rdata;

`ifdef NW_FILL_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Column 0 lives in row0_q, so the buffer only ever needs one write per cycle.
  assign buf_we    = !abort_hit && ((state_q == INIT) || ((state_q == WB) && mx_calc));
  assign buf_wdata = (state_q == INIT) ? init_val_q : mx_max;

  nw_row_buf #(
    .N  (N),
    .CW (CW)
  ) u_row_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (j_q),
    .wdata (buf_wdata),
    .raddr (j_q),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      diag_q       <= '0;
      left_q       <= '0;
      row0_q       <= '0;
      init_val_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mx_value_q   <= 1'b0;
      dir_we_q     <= 1'b0;
      seq_a_addr_q <= '0;
      seq_b_addr_q <= '0;
      dir_row_q    <= '0;
      dir_col_q    <= '0;
      dir_data_q   <= '0;
      mx_diag_q    <= '0;
      mx_up_q      <= '0;
      mx_lx_q      <= '0;
      final_q      <= '0;
    end else begin
      dir_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort_hit) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= INIT;
              busy_q     <= 1'b1;
              j_q        <= '0;
              init_val_q <= '0;
            end
          end
          INIT: begin
            init_val_q <= init_val_q + GAP_S;
            if (j_q == N_C) begin
              i_q          <= CW'(1);
              j_q          <= CW'(1);
              diag_q       <= '0;
              left_q       <= GAP_S;
              row0_q       <= GAP_S;
              seq_a_addr_q <= '0;
              seq_b_addr_q <= '0;
              state_q      <= FETCH;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
          FETCH: begin
            mx_diag_q <= diag_q;
            mx_up_q   <= buf_rdata;
            mx_lx_q   <= left_q;
            state_q   <= CALC;
          end
          CALC: begin
            mx_value_q <= (seq_a_data == seq_b_data);
            state_q    <= WB;
          end
          WB: begin
            if (mx_calc) begin
              dir_we_q   <= 1'b1;
              dir_row_q  <= AW'(i_q - 1'b1);
              dir_col_q  <= AW'(j_q - 1'b1);
              dir_data_q <= mx_symbol;
              if (j_q != N_C) begin
                j_q          <= j_q + 1'b1;
                diag_q       <= buf_rdata;
                left_q       <= mx_max;
                seq_b_addr_q <= AW'(j_q);
                state_q      <= FETCH;
              end else if (i_q != N_C) begin
                i_q          <= i_q + 1'b1;
                j_q          <= CW'(1);
                diag_q       <= row0_q;
                row0_q       <= row0_q + GAP_S;
                left_q       <= row0_q + GAP_S;
                seq_a_addr_q <= AW'(i_q);
                seq_b_addr_q <= '0;
                state_q      <= FETCH;
              end else begin
                final_q <= mx_max;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign seq_a_addr  = seq_a_addr_q;
  assign seq_b_addr  = seq_b_addr_q;
  assign mx_value    = mx_value_q;
  assign mx_diag     = mx_diag_q;
  assign mx_up       = mx_up_q;
  assign mx_lx       = mx_lx_q;
  assign dir_we      = dir_we_q;
  assign dir_row     = dir_row_q;
  assign dir_col     = dir_col_q;
  assign dir_data    = dir_data_q;
  assign final_score = final_q;

endmodule

// File: tb/tb_nw_fill_ctrl.sv
// tb/tb_nw_fill_ctrl.sv - randomized self-checking bench for nw_fill_ctrl against a full-matrix NW model
module tb_nw_fill_ctrl;

  localparam int N   = 4;
  localparam int GAP = -1;
  localparam int AW  = 2;
  localparam logic signed [8:0] GAP9 = 9'(GAP);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
`ifdef NW_FILL_ABORT_EN
  logic abort = 1'b0;
`endif
  logic busy, done, mx_value, mx_calc, dir_we;
  logic [AW-1:0] seq_a_addr, seq_b_addr, dir_row, dir_col;
  logic [1:0] seq_a_data, seq_b_data;
  logic signed [8:0] mx_diag, mx_up, mx_lx, mx_max, final_score;
  logic [2:0] mx_symbol, dir_data;

  int n_vec = 0, n_err = 0;
  int cyc = 0, st_cyc = 0;
  int wr_cnt = 0, done_cnt = 0, stall_we = 0;
  int stall_from = 0, stall_len = 0;

  logic [1:0] rom_a [N];
  logic [1:0] rom_b [N];
  int h [0:N][0:N];
  logic [2:0] exp_arw [N][N];
  int exp_final;

  nw_fill_ctrl #(.N(N), .GAP(GAP), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef NW_FILL_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .seq_a_addr  (seq_a_addr),
    .seq_a_data  (seq_a_data),
    .seq_b_addr  (seq_b_addr),
    .seq_b_data  (seq_b_data),
    .mx_value    (mx_value),
    .mx_diag     (mx_diag),
    .mx_up       (mx_up),
    .mx_lx       (mx_lx),
    .mx_max      (mx_max),
    .mx_symbol   (mx_symbol),
    .mx_calc     (mx_calc),
    .dir_we      (dir_we),
    .dir_row     (dir_row),
    .dir_col     (dir_col),
    .dir_data    (dir_data),
    .final_score (final_score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    seq_a_data <= rom_a[seq_a_addr];
    seq_b_data <= rom_b[seq_b_addr];
  end

  // Ideal max cell: +1 match / -1 mismatch, ties resolved diag, then up, then left.
  logic signed [8:0] sd, su, sl;
  always_comb begin
    sd = mx_diag + (mx_value ? 9'sd1 : -9'sd1);
    su = mx_up + GAP9;
    sl = mx_lx + GAP9;
    if (sd >= su && sd >= sl) begin
      mx_max = sd; mx_symbol = 3'b001;
    end else if (su >= sl) begin
      mx_max = su; mx_symbol = 3'b010;
    end else begin
      mx_max = sl; mx_symbol = 3'b100;
    end
  end

  assign mx_calc = !(stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len);

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic build_ref();
    int s, d, u, l;
    for (int i = 0; i <= N; i++) h[i][0] = i * GAP;
    for (int j = 0; j <= N; j++) h[0][j] = j * GAP;
    for (int i = 1; i <= N; i++) begin
      for (int j = 1; j <= N; j++) begin
        s = (rom_a[i-1] == rom_b[j-1]) ? 1 : -1;
        d = h[i-1][j-1] + s;
        u = h[i-1][j] + GAP;
        l = h[i][j-1] + GAP;
        if (d >= u && d >= l) begin h[i][j] = d; exp_arw[i-1][j-1] = 3'b001; end
        else if (u >= l)      begin h[i][j] = u; exp_arw[i-1][j-1] = 3'b010; end
        else                  begin h[i][j] = l; exp_arw[i-1][j-1] = 3'b100; end
      end
    end
    exp_final = h[N][N];
  endtask

  task automatic load_rand();
    for (int k = 0; k < N; k++) begin
      rom_a[k] = 2'($urandom_range(0, 3));
      rom_b[k] = 2'($urandom_range(0, 3));
    end
    build_ref();
  endtask

  always @(negedge clk) begin
    if (dir_we) begin
      if (wr_cnt < N * N) begin
        check("dir_row", int'(dir_row), wr_cnt / N);
        check("dir_col", int'(dir_col), wr_cnt % N);
        check("dir_data", int'(dir_data), int'(exp_arw[wr_cnt / N][wr_cnt % N]));
      end else begin
        check("dir_extra_write", wr_cnt, N * N - 1);
      end
      wr_cnt++;
      if (stall_len > 0 && cyc >= stall_from && cyc <= stall_from + stall_len) stall_we++;
    end
    if (done) done_cnt++;
  end

  task automatic do_start();
    @(negedge clk);
    wr_cnt = 0; done_cnt = 0; stall_we = 0;
    start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    else check("latency", cyc - st_cyc, exp_lat);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("write_count", wr_cnt, N * N);
    check("busy_after", int'(busy), 0);
    check("final_score", int'(final_score), exp_final);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_dir_we"}, int'(dir_we), 0);
    check({tag, "_mx_value"}, int'(mx_value), 0);
    check({tag, "_addr"}, int'({seq_a_addr, seq_b_addr, dir_row, dir_col}), 0);
    check({tag, "_operands"}, int'({mx_diag, mx_up, mx_lx}), 0);
    check({tag, "_dir_data"}, int'(dir_data), 0);
    check({tag, "_final"}, int'(final_score), 0);
  endtask

  initial begin
    int k, len, w, prev_final;
    rom_a = '{2'd0, 2'd1, 2'd2, 2'd3};
    rom_b = '{2'd0, 2'd1, 2'd2, 2'd3};
    build_ref();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identical sequences: score 4, diagonal arrows, 54-cycle latency.
    do_start();
    check("busy_running", int'(busy), 1);
    wait_done(54);
    check("final_acgt", int'(final_score), 4);

    // All mismatches.
    rom_a = '{2'd0, 2'd0, 2'd0, 2'd0};
    rom_b = '{2'd3, 2'd3, 2'd3, 2'd3};
    build_ref();
    do_start();
    wait_done(54);
    check("final_aaaa_tttt", int'(final_score), -4);

    // Five-cycle mx_calc stall at cell (2,3).
    load_rand();
    k = 1 * N + 2;
    do_start();
    stall_from = st_cyc + 1 + (N + 1) + 3 * k + 2;
    stall_len = 5;
    wait_done(54 + 5);
    check("stall_no_write", stall_we, 0);
    stall_len = 0;

    // A second start mid-fill is ignored.
    load_rand();
    do_start();
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(54);

    // Asynchronous reset mid-fill, then a clean fill.
    load_rand();
    do_start();
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    w = wr_cnt;
    repeat (6) @(negedge clk);
    check("writes_in_reset", wr_cnt, w);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_start();
    wait_done(54);

    // Random fills with a random stall anywhere in the matrix.
    for (int r = 0; r < 4; r++) begin
      load_rand();
      k = $urandom_range(0, N * N - 1);
      len = $urandom_range(1, 4);
      do_start();
      stall_from = st_cyc + 1 + (N + 1) + 3 * k + 2;
      stall_len = len;
      wait_done(54 + len);
      check("rand_stall_no_write", stall_we, 0);
      stall_len = 0;
    end

`ifdef NW_FILL_ABORT_EN
    prev_final = int'(final_score);
    load_rand();
    do_start();
    repeat (24) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    repeat (100) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_final_kept", int'(final_score), prev_final);
    do_start();
    wait_done(54);
`else
    prev_final = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
